// File: rtl/row_ctrl_pkg.sv
// rtl/row_ctrl_pkg.sv - shared types for the row access scheduler
package row_ctrl_pkg;

  localparam int ROW_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    ACT   = 2'd2,
    SENSE = 2'd3
  } state_t;

  typedef enum logic {
    OP_HOST    = 1'b0,
    OP_REFRESH = 1'b1
  } op_t;

endpackage

// File: rtl/refresh_timer.sv
// rtl/refresh_timer.sv - refresh interval counter with sticky pending flag
module refresh_timer #(
  parameter int INTERVAL = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic refresh_en,
  input  logic clear,
  output logic pending
);

  localparam int CNT_W = (INTERVAL > 2) ? $clog2(INTERVAL) : 1;

  logic [CNT_W-1:0] r_count;
  logic             r_pending;
  logic             w_expire;

  assign w_expire = (r_count == CNT_W'(INTERVAL - 1));

  // An expiry coinciding with a clear re-arms pending for the next interval.
  always_ff @(posedge clk) begin
    if (!rst_n || !refresh_en) begin
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      r_count <= w_expire ? '0 : r_count + CNT_W'(1);
      if (w_expire) begin
        r_pending <= 1'b1;
      end else if (clear) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign pending = r_pending;

endmodule

// File: rtl/row_access_sched.sv
// rtl/row_access_sched.sv - arbitrates host/refresh row ops and sequences PRE/ACT/SENSE
module row_access_sched
  import row_ctrl_pkg::*;
#(
  parameter int ROW_W            = ROW_W_DEFAULT,
  parameter int T_PRE            = 2,
  parameter int T_ACT            = 3,
  parameter int REFRESH_INTERVAL = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [ROW_W-1:0] req_row,
  output logic             req_ready,
  input  logic             refresh_en,
  output logic [ROW_W-1:0] row_addr,
  output logic             precharge,
  output logic             row_en,
  output logic             sense_en,
  output logic             done,
  output logic             done_refresh,
  output logic             busy
);

  localparam int PH_MAX = (T_PRE > T_ACT) ? T_PRE : T_ACT;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  state_t           r_state;
  state_t           w_next;
  logic [PH_W-1:0]  r_phase;
  logic [ROW_W-1:0] r_row_addr;
  logic [ROW_W-1:0] r_ref_ptr;
  op_t              r_op;
  logic             w_pending;
  logic             w_start_ref;
  logic             w_start_host;
  logic             w_phase_last;

  refresh_timer #(
    .INTERVAL(REFRESH_INTERVAL)
  ) u_refresh_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .refresh_en(refresh_en),
    .clear     (w_start_ref),
    .pending   (w_pending)
  );

  assign w_start_ref  = (r_state == IDLE) && w_pending;
  assign req_ready    = (r_state == IDLE) && !w_pending;
  assign w_start_host = req_valid && req_ready;
  assign w_phase_last = (r_phase == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start_ref || w_start_host) w_next = PRE;
      PRE:     if (w_phase_last) w_next = ACT;
      ACT:     if (w_phase_last) w_next = SENSE;
      SENSE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // One down-counter serves both timed phases; it is reloaded on entry to each.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_phase    <= '0;
      r_row_addr <= '0;
      r_ref_ptr  <= '0;
      r_op       <= OP_HOST;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_ref) begin
            r_row_addr <= r_ref_ptr;
            r_op       <= OP_REFRESH;
            r_phase    <= PH_W'(T_PRE - 1);
          end else if (w_start_host) begin
            r_row_addr <= req_row;
            r_op       <= OP_HOST;
            r_phase    <= PH_W'(T_PRE - 1);
          end
        end
        PRE:     r_phase <= w_phase_last ? PH_W'(T_ACT - 1) : r_phase - PH_W'(1);
        ACT:     if (!w_phase_last) r_phase <= r_phase - PH_W'(1);
        SENSE:   if (r_op == OP_REFRESH) r_ref_ptr <= r_ref_ptr + ROW_W'(1);
        default: ;
      endcase
    end
  end

  assign row_addr     = r_row_addr;
  assign precharge    = (r_state == PRE);
  assign row_en       = (r_state == ACT) || (r_state == SENSE);
  assign sense_en     = (r_state == SENSE);
  assign done         = (r_state == SENSE);
  assign done_refresh = (r_state == SENSE) && (r_op == OP_REFRESH);
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_row_access_sched.sv
// tb/tb_row_access_sched.sv - directed self-checking bench for row_access_sched
module tb_row_access_sched;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [4:0] req_row;
  logic       req_ready;
  logic       refresh_en;
  logic [4:0] row_addr;
  logic       precharge;
  logic       row_en;
  logic       sense_en;
  logic       done;
  logic       done_refresh;
  logic       busy;

  int n_checks;
  int n_bad;

  row_access_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_row     (req_row),
    .req_ready   (req_ready),
    .refresh_en  (refresh_en),
    .row_addr    (row_addr),
    .precharge   (precharge),
    .row_en      (row_en),
    .sense_en    (sense_en),
    .done        (done),
    .done_refresh(done_refresh),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_row    = 5'd0;
    refresh_en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks += 8;
    if (row_addr !== 5'd0) begin n_bad++; $display("FAIL reset_row_addr got=%0d want=0", row_addr); end
    if (precharge !== 1'b0) begin n_bad++; $display("FAIL reset_precharge got=%b want=0", precharge); end
    if (row_en !== 1'b0) begin n_bad++; $display("FAIL reset_row_en got=%b want=0", row_en); end
    if (sense_en !== 1'b0) begin n_bad++; $display("FAIL reset_sense_en got=%b want=0", sense_en); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
    if (done_refresh !== 1'b0) begin n_bad++; $display("FAIL reset_done_refresh got=%b want=0", done_refresh); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_host_read();
    logic e_pre, e_row, e_sense, e_busy, e_rdy;
    apply_reset();
    req_valid = 1'b1;
    req_row   = 5'd19;
    n_checks++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL host_ready_pre got=%b want=1", req_ready); end
    tick();
    req_valid = 1'b0;
    req_row   = 5'd3;
    for (int k = 1; k <= 7; k++) begin
      e_pre   = (k >= 1 && k <= 2);
      e_row   = (k >= 3 && k <= 6);
      e_sense = (k == 6);
      e_busy  = (k <= 6);
      e_rdy   = (k == 7);
      n_checks += 8;
      if (precharge !== e_pre) begin n_bad++; $display("FAIL host_precharge k=%0d got=%b want=%b", k, precharge, e_pre); end
      if (row_en !== e_row) begin n_bad++; $display("FAIL host_row_en k=%0d got=%b want=%b", k, row_en, e_row); end
      if (sense_en !== e_sense) begin n_bad++; $display("FAIL host_sense_en k=%0d got=%b want=%b", k, sense_en, e_sense); end
      if (done !== e_sense) begin n_bad++; $display("FAIL host_done k=%0d got=%b want=%b", k, done, e_sense); end
      if (done_refresh !== 1'b0) begin n_bad++; $display("FAIL host_done_refresh k=%0d got=%b want=0", k, done_refresh); end
      if (busy !== e_busy) begin n_bad++; $display("FAIL host_busy k=%0d got=%b want=%b", k, busy, e_busy); end
      if (req_ready !== e_rdy) begin n_bad++; $display("FAIL host_req_ready k=%0d got=%b want=%b", k, req_ready, e_rdy); end
      if (row_addr !== 5'd19) begin n_bad++; $display("FAIL host_row_addr k=%0d got=%0d want=19", k, row_addr); end
      tick();
    end
  endtask

  task automatic test_refresh_wrap();
    int idx;
    int last_t;
    logic [4:0] e_row;
    apply_reset();
    refresh_en = 1'b1;
    idx    = 0;
    last_t = 0;
    for (int t = 1; t <= 2130; t++) begin
      tick();
      if (done) begin
        e_row = idx[4:0];
        n_checks += 3;
        if (done_refresh !== 1'b1) begin n_bad++; $display("FAIL wrap_done_refresh idx=%0d got=%b want=1", idx, done_refresh); end
        if (row_addr !== e_row) begin n_bad++; $display("FAIL wrap_row_addr idx=%0d got=%0d want=%0d", idx, row_addr, e_row); end
        if (idx == 0) begin
          if (t != 70) begin n_bad++; $display("FAIL wrap_first_time got=%0d want=70", t); end
        end else begin
          if (t - last_t != 64) begin n_bad++; $display("FAIL wrap_spacing idx=%0d got=%0d want=64", idx, t - last_t); end
        end
        last_t = t;
        idx++;
      end
    end
    n_checks++;
    if (idx != 33) begin n_bad++; $display("FAIL wrap_count got=%0d want=33", idx); end
    refresh_en = 1'b0;
  endtask

  task automatic test_collision();
    int  exp_t[20];
    bit  exp_ref[20];
    int  n;
    int  idx;
    logic [4:0] e_row;
    n = 0;
    for (int i = 0; i < 10; i++) begin exp_t[n] = 6 + 7 * i; exp_ref[n] = 1'b0; n++; end
    exp_t[n] = 76; exp_ref[n] = 1'b1; n++;
    for (int i = 0; i < 8; i++) begin exp_t[n] = 83 + 7 * i; exp_ref[n] = 1'b0; n++; end
    exp_t[n] = 139; exp_ref[n] = 1'b1; n++;
    apply_reset();
    refresh_en = 1'b1;
    req_valid  = 1'b1;
    req_row    = 5'd7;
    idx = 0;
    for (int t = 1; t <= 145; t++) begin
      tick();
      if (t == 70) begin
        n_checks += 2;
        if (req_ready !== 1'b0) begin n_bad++; $display("FAIL coll_ready_blocked got=%b want=0", req_ready); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL coll_idle_busy got=%b want=0", busy); end
      end
      if (done) begin
        n_checks += 3;
        if (idx >= 20) begin
          n_bad++; $display("FAIL coll_extra_done t=%0d got=%0d dones want=20", t, idx + 1);
        end else begin
          e_row = exp_ref[idx] ? ((exp_t[idx] == 76) ? 5'd0 : 5'd1) : 5'd7;
          if (t != exp_t[idx]) begin n_bad++; $display("FAIL coll_done_time idx=%0d got=%0d want=%0d", idx, t, exp_t[idx]); end
          if (done_refresh !== exp_ref[idx]) begin n_bad++; $display("FAIL coll_done_type idx=%0d got=%b want=%b", idx, done_refresh, exp_ref[idx]); end
          if (row_addr !== e_row) begin n_bad++; $display("FAIL coll_row_addr idx=%0d got=%0d want=%0d", idx, row_addr, e_row); end
        end
        idx++;
      end
    end
    n_checks++;
    if (idx != 20) begin n_bad++; $display("FAIL coll_done_count got=%0d want=20", idx); end
    req_valid  = 1'b0;
    refresh_en = 1'b0;
  endtask

  task automatic test_refresh_disable();
    int n_ref;
    int first_t;
    apply_reset();
    refresh_en = 1'b1;
    req_valid  = 1'b1;
    req_row    = 5'd7;
    for (int t = 1; t <= 66; t++) tick();
    refresh_en = 1'b0;
    req_valid  = 1'b0;
    for (int t = 67; t <= 70; t++) tick();
    n_checks += 2;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL dis_ready_after_clear got=%b want=1", req_ready); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL dis_idle got=%b want=0", busy); end
    n_ref = 0;
    for (int t = 71; t <= 100; t++) begin
      tick();
      if (busy) n_ref++;
    end
    n_checks++;
    if (n_ref != 0) begin n_bad++; $display("FAIL dis_no_refresh busy_cycles got=%0d want=0", n_ref); end
    refresh_en = 1'b1;
    first_t = 0;
    for (int t = 1; t <= 75; t++) begin
      tick();
      if (done && first_t == 0) first_t = t;
    end
    n_checks++;
    if (first_t != 70) begin n_bad++; $display("FAIL dis_reenable_first got=%0d want=70", first_t); end
    refresh_en = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int n_done;
    apply_reset();
    req_valid = 1'b1;
    req_row   = 5'd12;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    n_checks += 2;
    if (row_en !== 1'b1 || precharge !== 1'b0) begin n_bad++; $display("FAIL mid_in_act row_en=%b precharge=%b want row_en=1 precharge=0", row_en, precharge); end
    if (row_addr !== 5'd12) begin n_bad++; $display("FAIL mid_row_addr got=%0d want=12", row_addr); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks += 5;
    if (row_addr !== 5'd0) begin n_bad++; $display("FAIL mid_rst_row_addr got=%0d want=0", row_addr); end
    if (row_en !== 1'b0) begin n_bad++; $display("FAIL mid_rst_row_en got=%b want=0", row_en); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_done got=%b want=0", done); end
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ready got=%b want=1", req_ready); end
    n_done = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (done) n_done++;
    end
    n_checks++;
    if (n_done != 0) begin n_bad++; $display("FAIL mid_no_done got=%0d want=0", n_done); end
  endtask

  initial begin
    n_checks   = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_row    = 5'd0;
    refresh_en = 1'b0;
    test_reset();
    test_host_read();
    test_refresh_wrap();
    test_collision();
    test_refresh_disable();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
